// File: rtl/lane_del_mutate_if.sv
// Gene stream bundle for the NEAT deletion lane.
//
// Handshake: in_valid qualifies genome_start-aligned gene_in/phase/random in
// the cycle it is high; there is no ready, so the sink takes one gene every
// cycle. out_valid qualifies gene_out one cycle later; gene_out is zero
// whenever out_valid is low. Nothing ever stalls.
interface lane_del_mutate_if #(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8
);
  logic               genome_start;
  logic               in_valid;
  logic [1:0]         phase;
  logic [GENE_SZ-1:0] gene_in;
  logic [ATTR_SZ-1:0] random;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_valid;

  modport master (
    output genome_start, in_valid, phase, gene_in, random,
    input  gene_out, out_valid
  );

  modport slave (
    input  genome_start, in_valid, phase, gene_in, random,
    output gene_out, out_valid
  );
endinterface

// File: rtl/lane_del_mutate.sv
// Per-lane NEAT deletion stage: drops hidden nodes on a random draw (bounded
// by DEL_DEPTH per genome), remembers their ids, and drops every connection
// that touches a remembered id or loses its own random draw.
module lane_del_mutate #(
  parameter int GENE_SZ   = 64,
  parameter int ATTR_SZ   = 8,
  parameter int DEL_DEPTH = 8,
  parameter int CNT_SZ    = 8
) (
  input  logic               clk,
  input  logic               rst,
  lane_del_mutate_if.slave   bus,
  input  logic [ATTR_SZ-1:0] node_del_prob,
  input  logic [ATTR_SZ-1:0] conn_del_prob,
  input  logic               node_del_en,
  input  logic               conn_del_en,
  output logic [CNT_SZ-1:0]  del_node_cnt,
  output logic [CNT_SZ-1:0]  del_conn_cnt,
  output logic               list_full,
  output logic               seq_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NODE = 2'd1,
    S_CONN = 2'd2
  } state_t;

  localparam logic [CNT_SZ-1:0] CNT_MAX = '1;
  localparam logic [CNT_SZ-1:0] DEPTH_C = CNT_SZ'(DEL_DEPTH);

  state_t               state_q, state_d;
  logic [ATTR_SZ-1:0]   list_id_q [DEL_DEPTH];
  logic [ATTR_SZ-1:0]   list_id_d [DEL_DEPTH];
  logic [DEL_DEPTH-1:0] list_vld_q, list_vld_d;
  logic [CNT_SZ-1:0]    node_cnt_q, node_cnt_d;
  logic [CNT_SZ-1:0]    conn_cnt_q, conn_cnt_d;
  logic                 list_full_q, list_full_d;
  logic                 seq_err_q, seq_err_d;
  logic [GENE_SZ-1:0]   gene_out_q, gene_out_d;
  logic                 out_valid_q, out_valid_d;

  // Views of the genome state after an optional genome_start clear, so the
  // gene arriving with genome_start sees an empty list and zero counters.
  state_t               st_eff;
  logic [DEL_DEPTH-1:0] vld_eff;
  logic [CNT_SZ-1:0]    ncnt_eff, ccnt_eff;
  logic                 serr_eff, full_eff;

  logic [1:0]           node_type;
  logic [ATTR_SZ-1:0]   id_f, dst_f;
  logic                 hit;

  // Next-state for the sequencing FSM, deletion list, counters and output.
  always_comb begin
    st_eff    = bus.genome_start ? S_IDLE : state_q;
    vld_eff   = bus.genome_start ? '0 : list_vld_q;
    ncnt_eff  = bus.genome_start ? '0 : node_cnt_q;
    ccnt_eff  = bus.genome_start ? '0 : conn_cnt_q;
    serr_eff  = bus.genome_start ? 1'b0 : seq_err_q;
    full_eff  = (ncnt_eff == DEPTH_C);

    node_type = bus.gene_in[7*ATTR_SZ-2 : 7*ATTR_SZ-3];
    id_f      = bus.gene_in[6*ATTR_SZ-1 : 5*ATTR_SZ];
    dst_f     = bus.gene_in[5*ATTR_SZ-1 : 4*ATTR_SZ];

    hit = 1'b0;
    for (int i = 0; i < DEL_DEPTH; i++) begin
      if (vld_eff[i] && (list_id_q[i] == id_f || list_id_q[i] == dst_f)) begin
        hit = 1'b1;
      end
    end

    state_d     = st_eff;
    list_vld_d  = vld_eff;
    list_id_d   = list_id_q;
    node_cnt_d  = ncnt_eff;
    conn_cnt_d  = ccnt_eff;
    seq_err_d   = serr_eff;
    gene_out_d  = '0;
    out_valid_d = 1'b0;

    if (bus.in_valid) begin
      case (bus.phase)
        2'b00: begin
          if (st_eff == S_CONN) begin
            // Out-of-order node: flag it and let it through untouched.
            seq_err_d   = 1'b1;
            gene_out_d  = bus.gene_in;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_NODE;
            if (node_del_en && (bus.random > node_del_prob) &&
                (node_type == 2'b00) && !full_eff) begin
              for (int i = 0; i < DEL_DEPTH; i++) begin
                if (CNT_SZ'(i) == ncnt_eff) begin
                  list_id_d[i]  = id_f;
                  list_vld_d[i] = 1'b1;
                end
              end
              node_cnt_d = (ncnt_eff == CNT_MAX) ? ncnt_eff : ncnt_eff + 1'b1;
            end else begin
              gene_out_d  = bus.gene_in;
              out_valid_d = 1'b1;
            end
          end
        end
        2'b10: begin
          state_d = S_CONN;
          if (hit || (conn_del_en && (bus.random > conn_del_prob))) begin
            conn_cnt_d = (ccnt_eff == CNT_MAX) ? ccnt_eff : ccnt_eff + 1'b1;
          end else begin
            gene_out_d  = bus.gene_in;
            out_valid_d = 1'b1;
          end
        end
        default: begin
          seq_err_d = 1'b1;
        end
      endcase
    end

    list_full_d = (node_cnt_d == DEPTH_C);
  end

  // Register all genome state and the one-cycle-latency output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      list_vld_q  <= '0;
      for (int i = 0; i < DEL_DEPTH; i++) list_id_q[i] <= '0;
      node_cnt_q  <= '0;
      conn_cnt_q  <= '0;
      list_full_q <= 1'b0;
      seq_err_q   <= 1'b0;
      gene_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_vld_q  <= list_vld_d;
      for (int i = 0; i < DEL_DEPTH; i++) list_id_q[i] <= list_id_d[i];
      node_cnt_q  <= node_cnt_d;
      conn_cnt_q  <= conn_cnt_d;
      list_full_q <= list_full_d;
      seq_err_q   <= seq_err_d;
      gene_out_q  <= gene_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.gene_out  = gene_out_q;
  assign bus.out_valid = out_valid_q;
  assign del_node_cnt  = node_cnt_q;
  assign del_conn_cnt  = conn_cnt_q;
  assign list_full     = list_full_q;
  assign seq_err       = seq_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lane_del_mutate.sv
// Bench for lane_del_mutate: two instances (DEL_DEPTH 8 and 2) share one
// stimulus stream and are compared against a list-based reference model.
module tb_lane_del_mutate;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        genome_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  phase = 2'b00;
  logic [63:0] gene_in = '0;
  logic [7:0]  rnd = '0;
  logic [7:0]  node_del_prob = 8'h80;
  logic [7:0]  conn_del_prob = 8'h80;
  logic        node_del_en = 1'b1;
  logic        conn_del_en = 1'b0;

  lane_del_mutate_if #(.GENE_SZ(64), .ATTR_SZ(8)) bus_a ();
  lane_del_mutate_if #(.GENE_SZ(64), .ATTR_SZ(8)) bus_b ();

  assign bus_a.genome_start = genome_start;
  assign bus_a.in_valid     = in_valid;
  assign bus_a.phase        = phase;
  assign bus_a.gene_in      = gene_in;
  assign bus_a.random       = rnd;
  assign bus_b.genome_start = genome_start;
  assign bus_b.in_valid     = in_valid;
  assign bus_b.phase        = phase;
  assign bus_b.gene_in      = gene_in;
  assign bus_b.random       = rnd;

  logic [7:0] ncnt_a, ccnt_a, ncnt_b, ccnt_b;
  logic       full_a, serr_a, full_b, serr_b;
  logic [1:0] st_a, st_b;

  lane_del_mutate #(.GENE_SZ(64), .ATTR_SZ(8), .DEL_DEPTH(8), .CNT_SZ(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .node_del_prob(node_del_prob), .conn_del_prob(conn_del_prob),
    .node_del_en(node_del_en), .conn_del_en(conn_del_en),
    .del_node_cnt(ncnt_a), .del_conn_cnt(ccnt_a),
    .list_full(full_a), .seq_err(serr_a), .state_dbg(st_a)
  );

  lane_del_mutate #(.GENE_SZ(64), .ATTR_SZ(8), .DEL_DEPTH(2), .CNT_SZ(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .node_del_prob(node_del_prob), .conn_del_prob(conn_del_prob),
    .node_del_en(node_del_en), .conn_del_en(conn_del_en),
    .del_node_cnt(ncnt_b), .del_conn_cnt(ccnt_b),
    .list_full(full_b), .seq_err(serr_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: list of deleted ids, counts, sticky error, and whether
  // a connection gene has already been seen in this genome.
  int m_ids  [2][16];
  int m_n    [2];
  int m_c    [2];
  bit m_serr [2];
  bit m_conn [2];
  bit e_ov   [2];

  task automatic model_clear(input int k);
    m_n[k] = 0; m_c[k] = 0; m_serr[k] = 0; m_conn[k] = 0;
  endtask

  task automatic model_step(input int k, input int depth);
    int ty, id, dst;
    bit hit, ov;
    logic [63:0] go;
    if (genome_start) model_clear(k);
    ov = 0; go = '0;
    ty  = int'(gene_in[54:53]);
    id  = int'(gene_in[47:40]);
    dst = int'(gene_in[39:32]);
    if (in_valid) begin
      if (phase == 2'b00) begin
        if (m_conn[k]) begin
          m_serr[k] = 1; ov = 1; go = gene_in;
        end else if (node_del_en && rnd > node_del_prob && ty == 0 && m_n[k] < depth) begin
          m_ids[k][m_n[k]] = id;
          m_n[k]++;
        end else begin
          ov = 1; go = gene_in;
        end
      end else if (phase == 2'b10) begin
        m_conn[k] = 1;
        hit = 0;
        for (int j = 0; j < m_n[k]; j++)
          if (m_ids[k][j] == id || m_ids[k][j] == dst) hit = 1;
        if (hit || (conn_del_en && rnd > conn_del_prob)) begin
          if (m_c[k] < 255) m_c[k]++;
        end else begin
          ov = 1; go = gene_in;
        end
      end else begin
        m_serr[k] = 1;
      end
    end
    exp_q.push_back(go);
    e_ov[k] = ov;
  endtask

  task automatic check_inst(input int k, input int depth, input logic [63:0] go, input logic ov,
                            input logic [7:0] nc, input logic [7:0] cc,
                            input logic lf, input logic se);
    logic [63:0] eg;
    string p;
    p = (k == 0) ? "a" : "b";
    if (exp_q.size() == 0) begin
      check_eq({p, ".exp_q_empty"}, 64'd1, 64'd0);
      eg = '0;
    end else begin
      eg = exp_q.pop_front();
    end
    check_eq({p, ".gene_out"},     go, eg);
    check_eq({p, ".out_valid"},    64'(ov), 64'(e_ov[k]));
    check_eq({p, ".del_node_cnt"}, 64'(nc), 64'(m_n[k]));
    check_eq({p, ".del_conn_cnt"}, 64'(cc), 64'(m_c[k]));
    check_eq({p, ".list_full"},    64'(lf), 64'(m_n[k] == depth));
    check_eq({p, ".seq_err"},      64'(se), 64'(m_serr[k]));
  endtask

  task automatic check_both();
    check_inst(0, 8, bus_a.gene_out, bus_a.out_valid, ncnt_a, ccnt_a, full_a, serr_a);
    check_inst(1, 2, bus_b.gene_out, bus_b.out_valid, ncnt_b, ccnt_b, full_b, serr_b);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      e_ov[k] = 0;
      exp_q.push_back('0);
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [63:0] mk_gene(input logic [1:0] ty, input logic [7:0] id, input logic [7:0] dst);
    logic [63:0] g;
    g = {$urandom, $urandom};
    g[54:53] = ty;
    g[47:40] = id;
    g[39:32] = dst;
    return g;
  endfunction

  // Apply one input cycle, let the DUT clock it, then compare at #1.
  task automatic step(input bit gs, input bit v, input logic [1:0] ph,
                      input logic [63:0] g, input logic [7:0] r);
    genome_start = gs; in_valid = v; phase = ph; gene_in = g; rnd = r;
    @(posedge clk); #1;
    model_step(0, 8);
    model_step(1, 2);
    check_both();
    genome_start = 0; in_valid = 0;
  endtask

  task automatic node(input bit gs, input logic [1:0] ty, input logic [7:0] id, input logic [7:0] r);
    step(gs, 1, 2'b00, mk_gene(ty, id, 8'h00), r);
  endtask

  task automatic conn(input bit gs, input logic [7:0] s, input logic [7:0] d, input logic [7:0] r);
    step(gs, 1, 2'b10, mk_gene(2'b00, s, d), r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit in_conns;
    int sel;
    logic [1:0] ty;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_both();
    rst = 1'b1;

    // Four hidden nodes 3..6 all over threshold; depth-2 instance keeps 5,6
    node_del_en = 1; node_del_prob = 8'h80; conn_del_en = 0; conn_del_prob = 8'h80;
    node(1, 2'b00, 8'd3, 8'hFF);
    node(0, 2'b00, 8'd4, 8'hFF);
    node(0, 2'b00, 8'd5, 8'hFF);
    node(0, 2'b00, 8'd6, 8'hFF);
    // Probe list contents through connection matching (src and dest sides)
    conn(0, 8'd3, 8'd9, 8'h00);
    conn(0, 8'd9, 8'd4, 8'h00);
    conn(0, 8'd5, 8'd9, 8'h00);
    conn(0, 8'd9, 8'd6, 8'h00);
    conn(0, 8'd9, 8'd10, 8'h00);

    // Input/output node type is never deleted
    node(1, 2'b01, 8'd7, 8'hFF);
    // Threshold boundary: random == prob is not "greater"
    node(0, 2'b00, 8'd8, 8'h80);
    node(0, 2'b00, 8'd8, 8'h81);

    // Delete node 5, then connections 5->7, 2->5, 2->7
    node(1, 2'b00, 8'd5, 8'hFF);
    conn(0, 8'd5, 8'd7, 8'h00);
    conn(0, 8'd2, 8'd5, 8'h00);
    conn(0, 8'd2, 8'd7, 8'h00);
    // Probabilistic connection delete
    conn_del_en = 1;
    conn(0, 8'd2, 8'd7, 8'h81);
    conn(0, 8'd2, 8'd7, 8'h80);

    // Node after connections -> seq_err, gene passes through
    node(0, 2'b00, 8'd11, 8'hFF);
    // Idle cycle: nothing changes
    step(0, 0, 2'b00, mk_gene(2'b00, 8'd1, 8'd1), 8'hFF);
    // Illegal phases
    step(0, 1, 2'b01, mk_gene(2'b00, 8'd1, 8'd1), 8'hFF);
    step(0, 1, 2'b11, mk_gene(2'b00, 8'd1, 8'd1), 8'hFF);
    // genome_start clears and processes its own gene
    node(1, 2'b00, 8'd12, 8'hFF);
    // Genome with no nodes: IDLE -> CONN
    conn(1, 8'd12, 8'd1, 8'h00);

    // Reset in the middle of CONN
    node(1, 2'b00, 8'd20, 8'hFF);
    conn(0, 8'd1, 8'd2, 8'h00);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_both();
    @(posedge clk); #1;
    rst = 1'b1;
    conn_del_en = 1; conn_del_prob = 8'h80;
    conn(0, 8'd20, 8'd2, 8'h00);

    // Randomized genomes
    in_conns = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        genome_start = 1;
        in_conns = 0;
        node_del_en   = ($urandom_range(0, 4) != 0);
        conn_del_en   = ($urandom_range(0, 2) != 0);
        node_del_prob = 8'($urandom_range(0, 255));
        conn_del_prob = 8'($urandom_range(64, 255));
      end
      sel = $urandom_range(0, 59);
      if (!in_conns && $urandom_range(0, 5) == 0) in_conns = 1;
      ty = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (sel == 0)
        step(genome_start, 1, 2'($urandom_range(0, 1) * 2 + 1), mk_gene(ty, 8'd0, 8'd0), 8'($urandom));
      else if (sel == 1 || !in_conns)
        step(genome_start, $urandom_range(0, 9) != 0, 2'b00,
             mk_gene(ty, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))), 8'($urandom));
      else
        step(genome_start, $urandom_range(0, 9) != 0, 2'b10,
             mk_gene(ty, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_del_mutate.md
# lane_del_mutate

Parametrised per-lane NEAT deletion stage. Consumes a genome as a stream of node genes followed by connection genes, probabilistically deletes hidden nodes (up to a configurable depth), and deletes every connection touching a deleted node or failing a connection-delete draw. It sits in the mutation lane after stage0 and replaces the fixed-depth deletion lane. Unlike that lane, it adds an input valid, per-genome list clearing, sequencing checks, deletion statistics and per-mode enables.

## Interface
- GENE_SZ, 64, gene width; must be ≥ 7*ATTR_SZ.
- ATTR_SZ, 8, attribute/node-id width.
- DEL_DEPTH, 8, max hidden nodes deleted per genome; range 1..16.
- CNT_SZ, 8, width of statistics counters.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- genome_start  in  1  one-cycle pulse marking the first gene of a new genome.
- in_valid  in  1  gene_in/phase/random qualified this cycle.
- phase  in  2  2'b00 node gene, 2'b10 connection gene, others illegal.
- gene_in  in  GENE_SZ  gene word.
- random  in  ATTR_SZ  fresh random draw per gene.
- node_del_prob  in  ATTR_SZ  node-delete threshold.
- conn_del_prob  in  ATTR_SZ  connection-delete threshold.
- node_del_en  in  1  enables probabilistic node deletion.
- conn_del_en  in  1  enables probabilistic connection deletion.
- gene_out  out  GENE_SZ  surviving gene; zero when not valid.
- out_valid  out  1  gene_out carries a kept gene.
- del_node_cnt  out  CNT_SZ  nodes deleted in the current genome.
- del_conn_cnt  out  CNT_SZ  connections deleted in the current genome.
- list_full  out  1  del_node_cnt == DEL_DEPTH.
- seq_err  out  1  sticky; node gene received after connection genes or illegal phase with in_valid.

## Operation
- Field positions: node_type = gene_in[7*ATTR_SZ-2 : 7*ATTR_SZ-3] (2'b00 = hidden), node_id/src = gene_in[6*ATTR_SZ-1 : 5*ATTR_SZ], dest = gene_in[5*ATTR_SZ-1 : 4*ATTR_SZ].
- Deletion list: DEL_DEPTH entries of ATTR_SZ bits, each with a valid bit. Write pointer = del_node_cnt.
- FSM states: IDLE, NODE, CONN.
  - IDLE→NODE on an in_valid node gene.
  - NODE→CONN on the first in_valid connection gene.
  - CONN stays in CONN.
  - Any state→IDLE-equivalent clear on genome_start. The gene in the same cycle is then processed from an empty list with counters at 0, and the FSM advances by that gene's phase.
  - IDLE→CONN is legal (genome with no nodes).
- Node gene: deleted iff node_del_en && random > node_del_prob && node_type == 2'b00 && !list_full. On deletion, node_id is written to entry del_node_cnt, that entry is marked valid, and del_node_cnt increments. Otherwise the gene is kept.
- Connection gene: deleted iff src or dest equals any valid list entry, or (conn_del_en && random > conn_del_prob). On deletion, del_conn_cnt increments. Otherwise the gene is kept.
- Node gene while in CONN: seq_err is set, the gene passes through unmodified, the list is not updated, and it is not counted.
- Illegal phase with in_valid: seq_err is set and there is no output.
- in_valid = 0: no state change, out_valid = 0.
- Counters saturate at 2^CNT_SZ-1.
- seq_err clears only on reset or genome_start.

## Timing
- Reset (rst low, asynchronous): gene_out = 0, out_valid = 0, del_node_cnt = 0, del_conn_cnt = 0, list_full = 0, seq_err = 0, all list valid bits = 0, FSM = IDLE.
- Latency is 1 cycle: gene_out/out_valid are registered from the cycle-N input.
- Full throughput: one gene per cycle with no stall and no back-pressure.
- A node deleted in cycle N is matchable by a connection in cycle N+1.
- Counters and list_full update in the same edge as gene_out.
- Reset mid-genome discards the list. The next genome must begin with genome_start or from IDLE.

## Test plan
- Reset then 4 hidden nodes (ids 3..6), random = 0xFF, node_del_prob = 0x80, node_del_en = 1 -> out_valid = 0 for all four; del_node_cnt = 4; list holds 3,4,5,6.
- DEL_DEPTH = 2, 3 deletable hidden nodes -> first two deleted, third kept (out_valid = 1, gene unchanged); list_full = 1.
- Input/output node (type 2'b01), random = 0xFF -> kept; del_node_cnt unchanged.
- Delete node 5, then connections 5->7, 2->5, 2->7 with random = 0x00 -> first two dropped, third kept one cycle later; del_conn_cnt = 2.
- Node gene after a connection gene -> seq_err = 1 and the gene passes through. Next genome_start -> seq_err = 0 and counters = 0; the first-cycle gene is processed.
- Assert rst low while in the middle of CONN -> all outputs 0 immediately. After release, a connection with src = previously deleted id is kept.
